// File: rtl/timer_set_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared types and default constants for the timer front-panel controller.
//   state_e       : RUN / SET_MIN / SET_HOUR adjust modes
//   DEF_*         : default debounce, hold, repeat and timeout constants
//   cnt_w()       : width of a counter that must hold values 0..n
// ----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } state_e;

  localparam int unsigned DEF_DEB_CYC  = 16;
  localparam int unsigned DEF_HOLD_CYC = 64;
  localparam int unsigned DEF_REP_CYC  = 16;
  localparam int unsigned DEF_TIMEOUT  = 10;

  // Counter width able to represent 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/timer_set_ctrl_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button: 2-FF synchronizer, stable-level
// counter and a one-cycle press pulse on the debounced rising edge.
// Raw-to-press latency is 2 + DEB_CYC cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : raw button level (asynchronous, active-high)
//   o_level    : debounced level
//   o_press    : one-cycle pulse on debounced rising edge
// ----------------------------------------------------------------------------
module btn_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = cnt_w(DEB_CYC);
  localparam logic [CW-1:0] TERM = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Stable counter: the level only flips after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == TERM) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/timer_set_ctrl.sv
// ----------------------------------------------------------------------------
// timer_set_ctrl
// Front-panel controller for the clock/timer: sequences the minute/hour adjust
// modes, drives the min/hour mux selects and produces a clean single-cycle
// adjust pulse (with hold-to-repeat) from the inc button.
// Optional feature macro: TIMER_SET_BLINK_EN (display blink generation); when
// undefined blink is tied to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_1hz   : one-cycle 1 Hz enable
//   btn_mode   : raw mode button
//   btn_inc    : raw increment button
//   min, hour  : adjust selects to the mux (never both 1)
//   inc_pulse  : one-cycle adjust pulse
//   busy       : high in any set mode
//   blink      : display blink enable
// ----------------------------------------------------------------------------
module timer_set_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned REP_CYC  = DEF_REP_CYC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1hz,
  input  logic btn_mode,
  input  logic btn_inc,
  output logic min,
  output logic hour,
  output logic inc_pulse,
  output logic busy,
  output logic blink
);

  localparam int unsigned RW = cnt_w(HOLD_CYC);
  localparam int unsigned TW = cnt_w(TIMEOUT);
  localparam logic [RW-1:0] REP_TERM   = RW'(HOLD_CYC - 1);
  // Reloading here makes the next terminal count arrive REP_CYC cycles later.
  localparam logic [RW-1:0] REP_RELOAD = RW'(HOLD_CYC - REP_CYC);
  localparam logic [TW-1:0] TO_TERM    = TW'(TIMEOUT - 1);

  logic w_press_mode;
  logic w_press_inc;
  logic w_inc_level;
  logic w_unused_mode_level;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep_nxt;
  logic [TW-1:0] r_to;
  logic [TW-1:0] w_to_nxt;
  logic          r_sup;
  logic          w_sup_nxt;
  logic          w_timeout;
  logic          w_mode_chg;
  logic          w_rep_en;
  logic          w_rep_fire;
  logic          w_inc_nxt;

  logic r_min;
  logic r_hour;
  logic r_inc_pulse;
  logic r_busy;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_mode),
    .o_level (w_unused_mode_level),
    .o_press (w_press_mode)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_inc),
    .o_level (w_inc_level),
    .o_press (w_press_inc)
  );

  // State and control counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_rep   <= '0;
      r_to    <= '0;
      r_sup   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rep   <= w_rep_nxt;
      r_to    <= w_to_nxt;
      r_sup   <= w_sup_nxt;
    end
  end

  // Next state, repeat/timeout counters and pulse decision.
  always_comb begin
    w_state_nxt = r_state;
    w_rep_nxt   = r_rep;
    w_to_nxt    = r_to;
    w_sup_nxt   = r_sup;
    w_rep_fire  = 1'b0;
    w_inc_nxt   = 1'b0;

    // Any button activity in the same cycle as the tick wins over the timeout.
    w_timeout = (r_state != RUN) && tick_1hz && !w_press_mode && !w_press_inc &&
                !r_inc_pulse && (r_to == TO_TERM);

    case (r_state)
      RUN: begin
        if (w_press_mode) w_state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (w_press_mode)   w_state_nxt = SET_HOUR;
        else if (w_timeout) w_state_nxt = RUN;
      end
      SET_HOUR: begin
        if (w_press_mode || w_timeout) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase

    w_mode_chg = (w_state_nxt != r_state);

    // Timeout counter: idle ticks in a set state only.
    if ((r_state == RUN) || w_mode_chg) begin
      w_to_nxt = '0;
    end else if (w_press_inc || r_inc_pulse) begin
      w_to_nxt = '0;
    end else if (tick_1hz) begin
      w_to_nxt = r_to + TW'(1);
    end

    // A mode change while inc is held blocks repeat until inc is released.
    if (!w_inc_level)    w_sup_nxt = 1'b0;
    else if (w_mode_chg) w_sup_nxt = 1'b1;

    // Repeat counter runs only while inc is held in a stable set state.
    w_rep_en = (r_state != RUN) && w_inc_level && !r_sup && !w_mode_chg;
    if (!w_rep_en) begin
      w_rep_nxt = '0;
    end else if (r_rep == REP_TERM) begin
      w_rep_nxt  = REP_RELOAD;
      w_rep_fire = 1'b1;
    end else begin
      w_rep_nxt = r_rep + RW'(1);
    end

    w_inc_nxt = (r_state != RUN) && !w_mode_chg && (w_press_inc || w_rep_fire);
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min       <= 1'b0;
      r_hour      <= 1'b0;
      r_busy      <= 1'b0;
      r_inc_pulse <= 1'b0;
    end else begin
      r_min       <= (w_state_nxt == SET_MIN);
      r_hour      <= (w_state_nxt == SET_HOUR);
      r_busy      <= (w_state_nxt != RUN);
      r_inc_pulse <= w_inc_nxt;
    end
  end

  assign min       = r_min;
  assign hour      = r_hour;
  assign busy      = r_busy;
  assign inc_pulse = r_inc_pulse;

`ifdef TIMER_SET_BLINK_EN
  logic       r_blink;
  logic [1:0] r_frc;

  // Blink toggles per tick; after an edit it is held on until a full tick
  // period has elapsed (two tick boundaries) so the digit stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= 1'b0;
      r_frc   <= 2'd0;
    end else if (w_state_nxt == RUN) begin
      r_blink <= 1'b0;
      r_frc   <= 2'd0;
    end else if (r_inc_pulse) begin
      r_blink <= 1'b1;
      r_frc   <= 2'd2;
    end else if (tick_1hz) begin
      if (r_frc != 2'd0) begin
        r_blink <= 1'b1;
        r_frc   <= r_frc - 2'd1;
      end else begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign blink = r_blink;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_timer_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_set_ctrl
// Self-checking bench for timer_set_ctrl with DEB_CYC=4, HOLD_CYC=8,
// REP_CYC=3, TIMEOUT=3. Expected inc_pulse cycles are queued when stimulus is
// driven and matched against a per-cycle log of the DUT output.
// ----------------------------------------------------------------------------
module tb_timer_set_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 3;
  localparam int unsigned TOUT = 3;
  localparam int          LOGN = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic tick_1hz;
  logic btn_mode;
  logic btn_inc;
  logic min;
  logic hour;
  logic inc_pulse;
  logic busy;
  logic blink;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic pulse_log [LOGN];
  int   sb [$];

  timer_set_ctrl #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .REP_CYC  (REP),
    .TIMEOUT  (TOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .min       (min),
    .hour      (hour),
    .inc_pulse (inc_pulse),
    .busy      (busy),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Cycle index k is visible at the negedge following the k-th posedge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) pulse_log[cyc[11:0]] <= inc_pulse;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Hold mode for 10 cycles and let the debounced level return low.
  task automatic press_mode_btn();
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_tick();
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({min, hour, inc_pulse, busy, blink} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected 00000", {min, hour, inc_pulse, busy, blink});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({min, hour, inc_pulse, busy, blink} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 00000", {min, hour, inc_pulse, busy, blink});
    end
  endtask

  task automatic test_mode_press();
    @(negedge clk);
    btn_mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        checks++;
        if (min !== 1'b0) begin
          errors++;
          $display("FAIL mode_early: min=%b expected 0 one cycle before latency", min);
        end
      end
      if (i == 7) begin
        checks++;
        if ({min, hour, busy} !== 3'b101) begin
          errors++;
          $display("FAIL mode_latency: min/hour/busy=%b expected 101", {min, hour, busy});
        end
      end
    end
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    // Two-cycle glitch must not advance SET_MIN to SET_HOUR.
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if ({min, hour, busy} !== 3'b101) begin
      errors++;
      $display("FAIL mode_glitch: min/hour/busy=%b expected 101", {min, hour, busy});
    end
  endtask

  task automatic test_mode_sequence();
    logic [1:0] exp_mh [3];
    exp_mh[0] = 2'b10;
    exp_mh[1] = 2'b01;
    exp_mh[2] = 2'b00;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      press_mode_btn();
      checks++;
      if ({min, hour, busy} !== {exp_mh[k], (k < 2) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL mode_seq[%0d]: min/hour/busy=%b expected %b", k, {min, hour, busy},
                 {exp_mh[k], (k < 2) ? 1'b1 : 1'b0});
      end
    end
  endtask

  task automatic test_inc_in_run();
    int n;
    logic exp_p;
    @(negedge clk);
    n = cyc;
    btn_inc = 1'b1;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    for (int c = n; c < cyc; c++) begin
      exp_p = (sb.size() > 0 && sb[0] == c);
      if (exp_p) void'(sb.pop_front());
      checks++;
      if (pulse_log[c[11:0]] !== exp_p) begin
        errors++;
        $display("FAIL inc_in_run cycle %0d: inc_pulse=%b expected %b", c, pulse_log[c[11:0]], exp_p);
      end
    end
  endtask

  task automatic test_inc_repeat();
    int n;
    logic exp_p;
    press_mode_btn();
    @(negedge clk);
    n = cyc;
    btn_inc = 1'b1;
    // Press pulse at n+6; outputs at +1, then HOLD, then every REP.
    sb.push_back(n + 7);
    sb.push_back(n + 14);
    sb.push_back(n + 17);
    sb.push_back(n + 20);
    sb.push_back(n + 23);
    repeat (18) @(negedge clk);
    btn_inc = 1'b0;
    repeat (20) @(negedge clk);
    for (int c = n; c < cyc; c++) begin
      exp_p = (sb.size() > 0 && sb[0] == c);
      if (exp_p) void'(sb.pop_front());
      checks++;
      if (pulse_log[c[11:0]] !== exp_p) begin
        errors++;
        $display("FAIL inc_repeat cycle %0d: inc_pulse=%b expected %b", c, pulse_log[c[11:0]], exp_p);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL inc_repeat_missing: %0d pulses outstanding expected 0", sb.size());
      sb.delete();
    end
    checks++;
    if ({min, hour} !== 2'b10) begin
      errors++;
      $display("FAIL inc_repeat_state: min/hour=%b expected 10", {min, hour});
    end
  endtask

  task automatic test_same_cycle();
    int n;
    logic exp_p;
    @(negedge clk);
    n = cyc;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) btn_mode = 1'b0;
      if (i == 7) begin
        checks++;
        if ({min, hour} !== 2'b01) begin
          errors++;
          $display("FAIL same_cycle_state: min/hour=%b expected 01", {min, hour});
        end
      end
    end
    btn_inc = 1'b0;
    repeat (14) @(negedge clk);
    for (int c = n; c < cyc; c++) begin
      exp_p = (sb.size() > 0 && sb[0] == c);
      if (exp_p) void'(sb.pop_front());
      checks++;
      if (pulse_log[c[11:0]] !== exp_p) begin
        errors++;
        $display("FAIL same_cycle cycle %0d: inc_pulse=%b expected %b", c, pulse_log[c[11:0]], exp_p);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    logic exp_p;
    // Currently SET_HOUR: three idle ticks return to RUN on the third.
    for (int t = 1; t <= 3; t++) begin
      repeat (5) @(negedge clk);
      send_tick();
      checks++;
      if (busy !== ((t < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL timeout_idle tick %0d: busy=%b expected %b", t, busy, (t < 3) ? 1'b1 : 1'b0);
      end
    end
    press_mode_btn();
    press_mode_btn();
    for (int t = 1; t <= 2; t++) begin
      repeat (5) @(negedge clk);
      send_tick();
    end
    @(negedge clk);
    n = cyc;
    btn_inc = 1'b1;
    sb.push_back(n + 7);
    repeat (6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    for (int c = n; c < cyc; c++) begin
      exp_p = (sb.size() > 0 && sb[0] == c);
      if (exp_p) void'(sb.pop_front());
      checks++;
      if (pulse_log[c[11:0]] !== exp_p) begin
        errors++;
        $display("FAIL timeout_inc cycle %0d: inc_pulse=%b expected %b", c, pulse_log[c[11:0]], exp_p);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_inc_missing: %0d pulses outstanding expected 0", sb.size());
      sb.delete();
    end
    for (int t = 1; t <= 3; t++) begin
      repeat (5) @(negedge clk);
      send_tick();
      checks++;
      if ({hour, busy} !== ((t < 3) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL timeout_deferred tick %0d: hour/busy=%b expected %b", t, {hour, busy},
                 (t < 3) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic exp_p;
    press_mode_btn();
    @(negedge clk);
    n = cyc;
    btn_inc = 1'b1;
    sb.push_back(n + 7);
    sb.push_back(n + 14);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({min, inc_pulse, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: min/inc_pulse/busy=%b expected 000", {min, inc_pulse, busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    for (int c = n; c < cyc; c++) begin
      exp_p = (sb.size() > 0 && sb[0] == c);
      if (exp_p) void'(sb.pop_front());
      checks++;
      if (pulse_log[c[11:0]] !== exp_p) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: inc_pulse=%b expected %b", c, pulse_log[c[11:0]], exp_p);
      end
    end
    checks++;
    if ({min, hour, busy, blink} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_state: min/hour/busy/blink=%b expected 0000", {min, hour, busy, blink});
    end
  endtask

  initial begin
    test_reset();
    test_mode_press();
    test_mode_sequence();
    test_inc_in_run();
    test_inc_repeat();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
